// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic sensor conditioning stage.
package traffic_pkg;

  // Encoding chosen so presence is simply state[1]:
  // PRESENT and HOLD both have the top bit set.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    QUALIFY = 2'b01,
    PRESENT = 2'b10,
    HOLD    = 2'b11
  } lane_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int HOLD_CYCLES_DEF     = 8;
  localparam int STUCK_CYCLES_DEF    = 1024;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

  // Counter must hold the largest terminal value, inclusive.
  function automatic int lane_cnt_width(input int d, input int h, input int s);
    return $clog2(max3(d, h, s) + 1);
  endfunction

endpackage

// File: rtl/sensor_lane_filter.sv
// One lane of vehicle-loop conditioning: 2-flop synchronizer, debounce
// qualification, presence hold after the vehicle leaves, and a sticky
// stuck-high fault flag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no vehicle; waiting for the first high synchronized sample
// QUALIFY | counting consecutive high samples toward DEBOUNCE_CYCLES
// PRESENT | vehicle reported; counting occupancy toward STUCK_CYCLES
// HOLD    | input dropped; presence extended for HOLD_CYCLES
module sensor_lane_filter
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic t,
  output logic fault
);

  localparam int CNT_W = lane_cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, STUCK_CYCLES);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_MAX  = CNT_W'(STUCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  lane_state_t      state;
  lane_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             fault_nxt;

  // Bring the asynchronous loop input into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Lane state, counter and sticky fault registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      fault <= fault_nxt;
    end
  end

  // Next-state, counter and fault decisions from the synchronized sample.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fault_nxt = fault;
    unique case (state)
      IDLE: begin
        if (sync2) begin
          state_nxt = QUALIFY;
          cnt_nxt   = CNT_ONE;
        end
      end
      QUALIFY: begin
        if (!sync2) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = PRESENT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESENT: begin
        // Fault is reported only; presence keeps being served.
        if (cnt >= STUCK_LAST) begin
          fault_nxt = 1'b1;
        end
        if (!sync2) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else if (cnt != STUCK_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (sync2) begin
          state_nxt = PRESENT;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Presence comes straight off a state flop, so it cannot glitch.
  assign t = state[1];

endmodule

// File: rtl/traffic_sensor_filter.sv
// Conditions the two raw loop detectors into clean ta/tb presence signals
// and stuck-sensor flags for the traffic light controller.
module traffic_sensor_filter
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_a_raw,
  input  logic sensor_b_raw,
  output logic ta,
  output logic tb,
  output logic fault_a,
  output logic fault_b
);

  sensor_lane_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_lane_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (sensor_a_raw),
    .t     (ta),
    .fault (fault_a)
  );

  sensor_lane_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_lane_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (sensor_b_raw),
    .t     (tb),
    .fault (fault_b)
  );

endmodule

// File: tb/tb_traffic_sensor_filter.sv
// Bench for traffic_sensor_filter with a run-length reference model.
module tb_traffic_sensor_filter;

  localparam int D = 4;
  localparam int H = 8;
  localparam int S = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sensor_a_raw = 1'b0;
  logic sensor_b_raw = 1'b0;
  logic ta, tb, fault_a, fault_b;

  int total = 0;
  int bad   = 0;

  // Reference model per lane: raw delay line, presence, fault, and the
  // lengths of the current high streak, low streak and occupancy.
  bit m_d1   [2];
  bit m_d2   [2];
  bit m_pres [2];
  bit m_fault[2];
  int m_high [2];
  int m_low  [2];
  int m_age  [2];

  traffic_sensor_filter #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .STUCK_CYCLES    (S)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_a_raw (sensor_a_raw),
    .sensor_b_raw (sensor_b_raw),
    .ta           (ta),
    .tb           (tb),
    .fault_a      (fault_a),
    .fault_b      (fault_b)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_d1[l] = 0; m_d2[l] = 0; m_pres[l] = 0; m_fault[l] = 0;
      m_high[l] = 0; m_low[l] = 0; m_age[l] = 0;
    end
  endtask

  // Presence: D consecutive high samples declare it; it is released on the
  // (H+1)-th consecutive low sample. Fault: occupancy of S cycles.
  task automatic model_edge(input bit ra, input bit rb);
    for (int l = 0; l < 2; l++) begin
      bit s;
      s = m_d2[l];
      m_d2[l] = m_d1[l];
      m_d1[l] = (l == 0) ? ra : rb;
      if (!m_pres[l]) begin
        if (s) begin
          m_high[l]++;
          if (m_high[l] == D) begin
            m_pres[l] = 1; m_high[l] = 0; m_age[l] = 0; m_low[l] = 0;
          end
        end else begin
          m_high[l] = 0;
        end
      end else if (m_low[l] == 0) begin
        if (m_age[l] >= S - 1) m_fault[l] = 1;
        if (s) m_age[l]++;
        else   m_low[l] = 1;
      end else begin
        if (s) begin
          m_low[l] = 0; m_age[l] = 0;
        end else begin
          m_low[l]++;
          if (m_low[l] == H + 1) begin
            m_pres[l] = 0; m_low[l] = 0; m_high[l] = 0;
          end
        end
      end
    end
  endtask

  // Advance one clock and leave time at posedge+1 for sampling/driving.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(sensor_a_raw, sensor_b_raw);
    #1;
  endtask

  task automatic settle();
    sensor_a_raw = 1'b0;
    sensor_b_raw = 1'b0;
    for (int i = 0; i < H + 8; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sensor_a_raw = 1'b0;
    sensor_b_raw = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({ta, tb, fault_a, fault_b} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=0000", i, {ta, tb, fault_a, fault_b});
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({ta, tb, fault_a, fault_b} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got=%b want=0000", i, {ta, tb, fault_a, fault_b});
      end
    end
  endtask

  task automatic test_rise();
    settle();
    sensor_a_raw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if (ta !== (k >= D + 1)) begin
        bad++;
        $display("FAIL rise_ta edge=N+%0d got=%b want=%b", k, ta, (k >= D + 1));
      end
      total++;
      if (tb !== 1'b0) begin
        bad++;
        $display("FAIL rise_tb edge=N+%0d got=%b want=0", k, tb);
      end
    end
  endtask

  task automatic test_bounce();
    bit pat[14] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    settle();
    for (int k = 0; k < 14; k++) begin
      sensor_a_raw = pat[k];
      tick();
      total++;
      if (ta !== 1'b0) begin
        bad++;
        $display("FAIL bounce_ta idx=%0d got=%b want=0", k, ta);
      end
    end
    // A clean assertion afterwards must see the full, unshortened latency.
    sensor_a_raw = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      total++;
      if (ta !== (k >= D + 1)) begin
        bad++;
        $display("FAIL bounce_requal edge=N+%0d got=%b want=%b", k, ta, (k >= D + 1));
      end
    end
  endtask

  task automatic test_fall();
    settle();
    sensor_a_raw = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    total++;
    if (ta !== 1'b1) begin
      bad++;
      $display("FAIL fall_pre got=%b want=1", ta);
    end
    sensor_a_raw = 1'b0;
    for (int k = 0; k < 13; k++) begin
      tick();
      total++;
      if (ta !== (k <= H + 1)) begin
        bad++;
        $display("FAIL fall_ta edge=M+%0d got=%b want=%b", k, ta, (k <= H + 1));
      end
    end
  endtask

  task automatic test_hold_both();
    bit exp_t;
    settle();
    for (int k = 0; k < 34; k++) begin
      sensor_a_raw = (k < 10) || (k >= 14 && k < 20);
      sensor_b_raw = sensor_a_raw;
      tick();
      exp_t = (k >= D + 1) && (k <= 20 + H + 1);
      total++;
      if (ta !== exp_t) begin
        bad++;
        $display("FAIL hold_ta idx=%0d got=%b want=%b", k, ta, exp_t);
      end
      total++;
      if (tb !== ta) begin
        bad++;
        $display("FAIL both_lanes idx=%0d tb=%b ta=%b", k, tb, ta);
      end
    end
  endtask

  task automatic test_stuck();
    settle();
    sensor_b_raw = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      total++;
      if (tb !== (k >= D + 1)) begin
        bad++;
        $display("FAIL stuck_tb idx=%0d got=%b want=%b", k, tb, (k >= D + 1));
      end
      total++;
      if (fault_b !== (k >= D + 1 + S)) begin
        bad++;
        $display("FAIL stuck_fault_b idx=%0d got=%b want=%b", k, fault_b, (k >= D + 1 + S));
      end
      total++;
      if ({ta, fault_a} !== 2'b00) begin
        bad++;
        $display("FAIL stuck_lane_a idx=%0d got=%b want=00", k, {ta, fault_a});
      end
    end
    sensor_b_raw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if ({tb, fault_b} !== 2'b11) begin
        bad++;
        $display("FAIL stuck_sticky edge=M+%0d got=%b want=11", k, {tb, fault_b});
      end
    end
    // Lane B is in HOLD now; reset between edges must clear it at once.
    #2 rst = 1'b1;
    model_reset();
    #1;
    total++;
    if ({tb, fault_b} !== 2'b00) begin
      bad++;
      $display("FAIL async_reset got=%b want=00", {tb, fault_b});
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    int shown = 0;
    for (int c = 0; c < 3000; c++) begin
      int div;
      div = (((c / 400) % 2) == 1) ? 48 : 5;
      if ($urandom_range(div - 1, 0) == 0) sensor_a_raw = ~sensor_a_raw;
      if ($urandom_range(div - 1, 0) == 0) sensor_b_raw = ~sensor_b_raw;
      if ((c % 750) == 749) begin
        #2 rst = 1'b1;
        model_reset();
        #1;
        total++;
        if ({ta, tb, fault_a, fault_b} !== 4'b0000) begin
          bad++;
          $display("FAIL rand_async_reset c=%0d got=%b want=0000", c, {ta, tb, fault_a, fault_b});
        end
        tick();
        rst = 1'b0;
      end
      tick();
      total++;
      if ({ta, tb, fault_a, fault_b} !== {m_pres[0], m_pres[1], m_fault[0], m_fault[1]}) begin
        bad++;
        if (shown < 20) begin
          shown++;
          $display("FAIL rand_model c=%0d got=%b want=%b", c, {ta, tb, fault_a, fault_b},
                   {m_pres[0], m_pres[1], m_fault[0], m_fault[1]});
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rise();
    test_bounce();
    test_fall();
    test_hold_both();
    test_stuck();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_sensor_filter.md
Name: traffic_sensor_filter

Overview:
- Upstream conditioning stage for the traffic light controller.
- Takes two raw, asynchronous, bouncy vehicle-loop inputs and produces the clean, synchronous ta/tb presence signals the controller consumes.
- Per lane: 2-flop synchronizer, debounce qualification, minimum-hold extension after the vehicle leaves, and sticky stuck-high fault detection.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized-high samples needed to declare presence; legal range >= 2.
- HOLD_CYCLES, 8: cycles that presence is held after the synchronized input drops; legal range >= 1.
- STUCK_CYCLES, 1024: consecutive PRESENT-state cycles after which the lane fault is flagged; legal range > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sensor_a_raw  in  1  raw loop detector, lane A; asynchronous to clk.
- sensor_b_raw  in  1  raw loop detector, lane B; asynchronous to clk.
- ta  out  1  filtered traffic-present, lane A; drives controller ta.
- tb  out  1  filtered traffic-present, lane B; drives controller tb.
- fault_a  out  1  sticky stuck-sensor flag, lane A.
- fault_b  out  1  sticky stuck-sensor flag, lane B.

Behaviour:
- Reset (rst=1, async): sync flops=0, lane FSMs=IDLE, counters=0, ta=tb=0, fault_a=fault_b=0. Reset asserted mid-operation aborts immediately to this state, with no hold extension.
- Lanes are fully independent and identical. Simultaneous activity on both lanes has no interaction.
- Synchronizer: sync1 <= raw; sync2 <= sync1. The FSM sees only sync2.
- Lane FSM (cnt width = $clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES, STUCK_CYCLES)+1)):
  - IDLE (t=0): sync2=1 -> QUALIFY, cnt<=1.
  - QUALIFY (t=0): sync2=0 -> IDLE, cnt<=0. sync2=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESENT, cnt<=0. Otherwise cnt++.
  - PRESENT (t=1): sync2=0 -> HOLD, cnt<=0. Otherwise cnt saturates at STUCK_CYCLES. When cnt reaches STUCK_CYCLES-1, fault<=1 (sticky until rst).
  - HOLD (t=1): sync2=1 -> PRESENT, cnt<=0. cnt==HOLD_CYCLES-1 -> IDLE. Otherwise cnt++.
- t is decoded from the registered state (PRESENT or HOLD), so it is glitch-free with no combinational path from inputs.
- Rise latency: raw first sampled high at posedge N and held high -> t=1 after posedge N+DEBOUNCE_CYCLES+1.
- Any low sync2 sample during QUALIFY restarts qualification from IDLE.
- Fall latency: raw first sampled low at posedge M, not re-asserted -> t=0 after posedge M+HOLD_CYCLES+2.
- Re-assertion during HOLD returns to PRESENT with no t dropout.
- Fault does not force t. The lane keeps reporting presence (fail-safe: the controller still serves the lane).

Decomposition:
- Shared package traffic_pkg:
  - lane_state_t enum {IDLE, QUALIFY, PRESENT, HOLD}.
  - Default constants DEBOUNCE_CYCLES_DEF, HOLD_CYCLES_DEF, STUCK_CYCLES_DEF.
- Sub-module sensor_lane_filter: synchronizer, FSM, counter and fault for one lane, with ports clk, rst, raw, t, fault.
- The top instantiates it twice (A and B) and passes the parameters through.

Test Plan:
- Reset 20 cycles with raw=0, then release: ta=tb=fault_a=fault_b=0 during and after reset.
- sensor_a_raw 0->1 sampled at posedge N, held: ta=1 after posedge N+5 (D=4); tb stays 0.
- Bounce: raw A high 3 cycles, low 1, high 2, low: ta never asserts; FSM back in IDLE.
- Raw A high 10 cycles, then low at posedge M: ta stays 1 through posedge M+9, and is 0 after M+10 (H=8).
- Raw A dropped for 4 cycles during HOLD, then re-asserted: ta remains 1 continuously. Both lanes driven simultaneously with identical stimulus: ta and tb identical cycle-for-cycle.
- With STUCK_CYCLES=32, hold raw B high 60 cycles: fault_b=1 once PRESENT has lasted 32 cycles and stays 1 after raw drops. Assert rst mid-HOLD: tb and fault_b go 0 immediately, asynchronously.
